// File: rtl/perf_sample_sequencer_pkg.sv
// Shared types, constants and CSR address helper for the perf sample sequencer.
// Counter addresses follow the mhpmcounter3.. / mhpmcounter3h.. CSR map.
package perf_sample_sequencer_pkg;

   localparam int unsigned NUM_COUNTERS   = 6;
   localparam int unsigned PERF_REC_WORDS = NUM_COUNTERS + 1;
   localparam int unsigned IDX_W          = 3;

   localparam logic [11:0] CSR_MHPM_COUNTER_3  = 12'hB03;
   localparam logic [11:0] CSR_MHPM_COUNTER_3H = 12'hB83;

   typedef enum logic [1:0] {
      PERF_SEQ_IDLE  = 2'd0,
      PERF_SEQ_READ  = 2'd1,
      PERF_SEQ_WRITE = 2'd2,
      PERF_SEQ_CLEAR = 2'd3
   } perf_seq_state_e;

   function automatic logic [11:0] perf_cnt_addr(input logic [IDX_W-1:0] idx, input logic hi);
      logic [11:0] base_s;
      if (hi) begin
         base_s = CSR_MHPM_COUNTER_3H;
      end else begin
         base_s = CSR_MHPM_COUNTER_3;
      end
      return base_s + {9'd0, idx};
   endfunction

endpackage

// File: rtl/perf_sample_sequencer_if.sv
// Record write port towards the memory/AXI adapter: req/gnt handshake with
// address and data held stable until the grant.
interface perf_sample_sequencer_if;
   logic        mem_req_o;
   logic [63:0] mem_addr_o;
   logic [63:0] mem_data_o;
   logic        mem_gnt_i;

   modport master (output mem_req_o, mem_addr_o, mem_data_o, input mem_gnt_i);
   modport slave  (input mem_req_o, mem_addr_o, mem_data_o, output mem_gnt_i);
endinterface

// File: rtl/perf_sample_sequencer_timer.sv
// Trigger source: periodic down-counter plus rising-edge detect on the perf IRQ.
// The counter reloads on 1 so that a tick recurs exactly every `period` cycles.
module perf_sample_sequencer_timer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable,
   input  logic        debug_mode,
   input  logic        irq,
   input  logic [31:0] period,
   output logic        trig
);

   logic [31:0] cnt_r;
   logic        irq_q_r;
   logic        tick_s;

   assign tick_s = (cnt_r == 32'd1) && (period != 32'd0);
   assign trig   = enable & ~debug_mode & ((irq & ~irq_q_r) | tick_s);

   // Period counter and IRQ history register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r   <= 32'd0;
         irq_q_r <= 1'b0;
      end else begin
         irq_q_r <= irq;
         if ((period == 32'd0) || (cnt_r <= 32'd1)) begin
            cnt_r <= period;
         end else begin
            cnt_r <= cnt_r - 32'd1;
         end
      end
   end

endmodule

// File: rtl/perf_sample_sequencer.sv
// Snapshot the generic perf counters on a trigger, stream them plus a sequence
// number to memory as one record, and optionally zero the counters afterwards.
module perf_sample_sequencer
   import perf_sample_sequencer_pkg::*;
#(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned NumCounters = NUM_COUNTERS,
   parameter int unsigned RecordWords = NumCounters + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  debug_mode_i,
   input  logic                  csr_req_i,
   input  logic [11:0]           csr_addr_i,
   input  logic                  csr_we_i,
   input  logic [XLEN-1:0]       csr_data_i,
   output logic [XLEN-1:0]       csr_data_o,
   output logic [11:0]           pc_addr_o,
   output logic                  pc_we_o,
   output logic [XLEN-1:0]       pc_data_o,
   input  logic [XLEN-1:0]       pc_data_i,
   input  logic                  irq_i,
   input  logic                  enable_i,
   input  logic                  clear_after_i,
   input  logic [31:0]           period_i,
   input  logic [63:0]           base_addr_i,
   perf_sample_sequencer_if.master mem,
   output logic                  busy_o,
   output logic                  overrun_o
);

   localparam bit Split = (XLEN == 32);

   perf_seq_state_e  state_r;
   logic [IDX_W-1:0] idx_r;
   logic             half_r;
   logic [63:0]      snap_r [NumCounters];
   logic [63:0]      seq_r;
   logic [63:0]      base_r;
   logic             clear_r;
   logic             overrun_r;
   logic             trig_s;
   logic             eng_s;
   logic             last_cnt_s;
   logic [63:0]      mem_data_s;

   perf_sample_sequencer_timer u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .enable     (enable_i),
      .debug_mode (debug_mode_i),
      .irq        (irq_i),
      .period     (period_i),
      .trig       (trig_s)
   );

   // The CSR file always wins the counter port; the engine only moves on free cycles.
   assign eng_s      = ~csr_req_i;
   assign last_cnt_s = (idx_r == IDX_W'(NumCounters - 1)) && (!Split || half_r);
   assign csr_data_o = pc_data_i;
   assign busy_o     = (state_r != PERF_SEQ_IDLE);
   assign overrun_o  = overrun_r;

   assign mem.mem_req_o  = (state_r == PERF_SEQ_WRITE);
   assign mem.mem_addr_o = (state_r == PERF_SEQ_WRITE) ? (base_r + {58'd0, idx_r, 3'd0}) : 64'd0;
   assign mem.mem_data_o = mem_data_s;

   // Counter-port arbitration between CSR file and engine.
   always_comb begin
      pc_addr_o = 12'd0;
      pc_we_o   = 1'b0;
      pc_data_o = '0;
      if (csr_req_i) begin
         pc_addr_o = csr_addr_i;
         pc_we_o   = csr_we_i;
         pc_data_o = csr_data_i;
      end else begin
         case (state_r)
            PERF_SEQ_READ: begin
               pc_addr_o = perf_cnt_addr(idx_r, half_r);
            end
            PERF_SEQ_CLEAR: begin
               pc_addr_o = perf_cnt_addr(idx_r, half_r);
               pc_we_o   = 1'b1;
            end
            default: begin
               pc_addr_o = 12'd0;
            end
         endcase
      end
   end

   // Record word selection: snapshots first, sequence number last.
   always_comb begin
      mem_data_s = 64'd0;
      if (state_r == PERF_SEQ_WRITE) begin
         if (idx_r == IDX_W'(NumCounters)) begin
            mem_data_s = seq_r;
         end else begin
            mem_data_s = snap_r[idx_r];
         end
      end else begin
         mem_data_s = 64'd0;
      end
   end

   // Sequencer FSM with snapshot buffer and record bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r   <= PERF_SEQ_IDLE;
         idx_r     <= '0;
         half_r    <= 1'b0;
         seq_r     <= 64'd0;
         base_r    <= 64'd0;
         clear_r   <= 1'b0;
         overrun_r <= 1'b0;
         for (int i = 0; i < NumCounters; i++) begin
            snap_r[i] <= 64'd0;
         end
      end else begin
         overrun_r <= trig_s && (state_r != PERF_SEQ_IDLE);
         case (state_r)
            PERF_SEQ_IDLE: begin
               if (trig_s) begin
                  state_r <= PERF_SEQ_READ;
                  base_r  <= base_addr_i;
                  clear_r <= clear_after_i;
                  idx_r   <= '0;
                  half_r  <= 1'b0;
               end
            end
            PERF_SEQ_READ: begin
               if (eng_s) begin
                  if (Split && !half_r) begin
                     snap_r[idx_r][31:0] <= pc_data_i[31:0];
                  end else if (Split) begin
                     snap_r[idx_r][63:32] <= pc_data_i[31:0];
                  end else begin
                     snap_r[idx_r][XLEN-1:0] <= pc_data_i;
                  end
                  if (last_cnt_s) begin
                     state_r <= PERF_SEQ_WRITE;
                     idx_r   <= '0;
                     half_r  <= 1'b0;
                  end else if (Split && !half_r) begin
                     half_r <= 1'b1;
                  end else begin
                     half_r <= 1'b0;
                     idx_r  <= idx_r + IDX_W'(1);
                  end
               end
            end
            PERF_SEQ_WRITE: begin
               if (mem.mem_gnt_i) begin
                  if (idx_r == IDX_W'(RecordWords - 1)) begin
                     seq_r   <= seq_r + 64'd1;
                     idx_r   <= '0;
                     state_r <= clear_r ? PERF_SEQ_CLEAR : PERF_SEQ_IDLE;
                  end else begin
                     idx_r <= idx_r + IDX_W'(1);
                  end
               end
            end
            PERF_SEQ_CLEAR: begin
               if (eng_s) begin
                  if (last_cnt_s) begin
                     state_r <= PERF_SEQ_IDLE;
                     idx_r   <= '0;
                     half_r  <= 1'b0;
                  end else if (Split && !half_r) begin
                     half_r <= 1'b1;
                  end else begin
                     half_r <= 1'b0;
                     idx_r  <= idx_r + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_r <= PERF_SEQ_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perf_sample_sequencer.sv
// Directed bench for perf_sample_sequencer (XLEN=64) with a behavioural
// perf_counters model on the counter port.
module tb_perf_sample_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        debug_mode;
   logic        csr_req;
   logic [11:0] csr_addr;
   logic        csr_we;
   logic [63:0] csr_wdata;
   logic [63:0] csr_rdata;
   logic [11:0] pc_addr;
   logic        pc_we;
   logic [63:0] pc_wdata;
   logic [63:0] pc_rdata;
   logic        irq;
   logic        enable;
   logic        clear_after;
   logic [31:0] period;
   logic [63:0] base_addr;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   perf_sample_sequencer_if mem_if ();

   perf_sample_sequencer #(.XLEN(64)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .debug_mode_i  (debug_mode),
      .csr_req_i     (csr_req),
      .csr_addr_i    (csr_addr),
      .csr_we_i      (csr_we),
      .csr_data_i    (csr_wdata),
      .csr_data_o    (csr_rdata),
      .pc_addr_o     (pc_addr),
      .pc_we_o       (pc_we),
      .pc_data_o     (pc_wdata),
      .pc_data_i     (pc_rdata),
      .irq_i         (irq),
      .enable_i      (enable),
      .clear_after_i (clear_after),
      .period_i      (period),
      .base_addr_i   (base_addr),
      .mem           (mem_if),
      .busy_o        (busy),
      .overrun_o     (overrun)
   );

   always #5 clk = ~clk;

   // Counter block model: six static counters at 0xB03..0xB08.
   logic [63:0] cnt_m [6] = '{default: 64'd0};
   logic [11:0] off_s;
   logic        hit_s;
   assign off_s = pc_addr - 12'hB03;
   assign hit_s = (pc_addr >= 12'hB03) && (pc_addr <= 12'hB08);

   always @(posedge clk) begin
      if (pc_we && hit_s) cnt_m[off_s[2:0]] <= pc_wdata;
   end

   always_comb begin
      pc_rdata = 64'd0;
      if (hit_s) pc_rdata = cnt_m[off_s[2:0]];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
      csr_req = 1'b1; csr_addr = a; csr_we = 1'b1; csr_wdata = d;
      step();
      csr_req = 1'b0; csr_we = 1'b0;
   endtask

   task automatic fire();
      irq = 1'b1;
      step();
      irq = 1'b0;
   endtask

   initial begin
      int starts [3];
      logic [63:0] seqw [3];
      int ns;
      int nq;
      int ovr;
      logic prev_busy;

      rst_n = 1'b0; debug_mode = 1'b0; csr_req = 1'b0; csr_addr = 12'd0; csr_we = 1'b0;
      csr_wdata = 64'd0; irq = 1'b0; enable = 1'b1; clear_after = 1'b0; period = 32'd0;
      base_addr = 64'h8000_0000; mem_if.mem_gnt_i = 1'b1;
      #12;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_req", {63'd0, mem_if.mem_req_o}, 64'd0);
      chk("rst_addr", mem_if.mem_addr_o, 64'd0);
      chk("rst_ovr", {63'd0, overrun}, 64'd0);
      chk("rst_pcaddr", {52'd0, pc_addr}, 64'd0);
      chk("rst_pcwe", {63'd0, pc_we}, 64'd0);
      chk("rst_csrdata", csr_rdata, pc_rdata);
      rst_n = 1'b1;
      step();

      // Basic record: counters 1..6, gnt always high.
      for (int i = 0; i < 6; i++) csr_write(12'hB03 + 12'(i), 64'(i + 1));
      step();
      fire();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t1_rdaddr%0d", i), {52'd0, pc_addr}, 64'hB03 + 64'(i));
         chk($sformatf("t1_rdwe%0d", i), {63'd0, pc_we}, 64'd0);
         step();
      end
      for (int w = 0; w < 7; w++) begin
         chk($sformatf("t1_req%0d", w), {63'd0, mem_if.mem_req_o}, 64'd1);
         chk($sformatf("t1_addr%0d", w), mem_if.mem_addr_o, 64'h8000_0000 + 64'(8 * w));
         chk($sformatf("t1_data%0d", w), mem_if.mem_data_o, (w == 6) ? 64'd0 : 64'(w + 1));
         step();
      end
      chk("t1_busy_end", {63'd0, busy}, 64'd0);
      chk("t1_req_end", {63'd0, mem_if.mem_req_o}, 64'd0);

      // Periodic trigger from a fresh reset: tick in cycles 100/200/300, record visible one edge later.
      rst_n = 1'b0;
      step();
      chk("t2_rst_busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;
      step();
      period = 32'd100;
      ns = 0; nq = 0; prev_busy = 1'b0;
      for (int c = 1; c <= 320; c++) begin
         step();
         if (busy && !prev_busy && ns < 3) begin starts[ns] = c; ns++; end
         if (mem_if.mem_req_o && mem_if.mem_gnt_i && mem_if.mem_addr_o == 64'h8000_0030 && nq < 3) begin
            seqw[nq] = mem_if.mem_data_o; nq++;
         end
         prev_busy = busy;
      end
      period = 32'd0;
      chk("t2_nstarts", 64'(ns), 64'd3);
      chk("t2_nseq", 64'(nq), 64'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < ns) chk($sformatf("t2_start%0d", k), 64'(starts[k]), 64'(101 + 100 * k));
         if (k < nq) chk($sformatf("t2_seq%0d", k), seqw[k], 64'(k));
      end
      step();

      // CSR stall in READ: 5 CSR cycles after idx0 is captured.
      for (int i = 0; i < 6; i++) csr_write(12'hB03 + 12'(i), 64'(10 * (i + 1)));
      step();
      fire();
      chk("t3_rd0", {52'd0, pc_addr}, 64'hB03);
      step();
      chk("t3_rd1", {52'd0, pc_addr}, 64'hB04);
      csr_req = 1'b1; csr_addr = 12'hB05; csr_we = 1'b0; csr_wdata = 64'hDEAD_BEEF;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("t3_mux_addr%0d", k), {52'd0, pc_addr}, 64'hB05);
         chk($sformatf("t3_mux_we%0d", k), {63'd0, pc_we}, 64'd0);
         chk($sformatf("t3_mux_wd%0d", k), pc_wdata, 64'hDEAD_BEEF);
         chk($sformatf("t3_csrrd%0d", k), csr_rdata, 64'd30);
         step();
      end
      csr_req = 1'b0;
      #1;
      chk("t3_resume", {52'd0, pc_addr}, 64'hB04);
      for (int i = 2; i < 6; i++) begin
         step();
         chk($sformatf("t3_rd%0d", i), {52'd0, pc_addr}, 64'hB03 + 64'(i));
      end
      step();
      for (int w = 0; w < 7; w++) begin
         chk($sformatf("t3_data%0d", w), mem_if.mem_data_o, (w == 6) ? 64'd3 : 64'(10 * (w + 1)));
         step();
      end
      chk("t3_busy_end", {63'd0, busy}, 64'd0);

      // Slow grant, base change mid-record and an overrun trigger.
      mem_if.mem_gnt_i = 1'b0;
      step();
      fire();
      repeat (6) step();
      base_addr = 64'h1234_0000;
      ovr = 0;
      for (int w = 0; w < 7; w++) begin
         for (int d = 0; d < 4; d++) begin
            if (overrun) ovr++;
            chk($sformatf("t4_req%0d_%0d", w, d), {63'd0, mem_if.mem_req_o}, 64'd1);
            chk($sformatf("t4_addr%0d_%0d", w, d), mem_if.mem_addr_o, 64'h8000_0000 + 64'(8 * w));
            chk($sformatf("t4_data%0d_%0d", w, d), mem_if.mem_data_o, (w == 6) ? 64'd4 : 64'(10 * (w + 1)));
            mem_if.mem_gnt_i = (d == 3);
            irq = (w == 2 && d == 0);
            step();
         end
      end
      mem_if.mem_gnt_i = 1'b1;
      if (overrun) ovr++;
      chk("t4_overrun_cycles", 64'(ovr), 64'd1);
      chk("t4_busy_end", {63'd0, busy}, 64'd0);
      base_addr = 64'h8000_0000;

      // Clear after record.
      clear_after = 1'b1;
      step();
      fire();
      repeat (13) step();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t5_clr_we%0d", i), {63'd0, pc_we}, 64'd1);
         chk($sformatf("t5_clr_addr%0d", i), {52'd0, pc_addr}, 64'hB03 + 64'(i));
         chk($sformatf("t5_clr_data%0d", i), pc_wdata, 64'd0);
         step();
      end
      chk("t5_busy_end", {63'd0, busy}, 64'd0);
      clear_after = 1'b0;
      csr_req = 1'b1; csr_addr = 12'hB03; csr_we = 1'b0;
      #1;
      chk("t5_csr_read", csr_rdata, 64'd0);
      csr_req = 1'b0;
      step();

      // Asynchronous reset in the middle of WRITE.
      mem_if.mem_gnt_i = 1'b0;
      fire();
      repeat (6) step();
      chk("t6_req_before", {63'd0, mem_if.mem_req_o}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_req_async", {63'd0, mem_if.mem_req_o}, 64'd0);
      chk("t6_busy_async", {63'd0, busy}, 64'd0);
      step();
      rst_n = 1'b1;
      mem_if.mem_gnt_i = 1'b1;
      step();
      fire();
      chk("t6_rd0", {52'd0, pc_addr}, 64'hB03);
      repeat (6) step();
      for (int w = 0; w < 7; w++) begin
         chk($sformatf("t6_addr%0d", w), mem_if.mem_addr_o, 64'h8000_0000 + 64'(8 * w));
         if (w == 6) chk("t6_seq", mem_if.mem_data_o, 64'd0);
         step();
      end
      chk("t6_busy_end", {63'd0, busy}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
